// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file writeback widths, indices and request type.
package rf_pkg;
    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 4;
    localparam int NREG       = 16;
    localparam int PC_IDX     = 15;
    localparam int STARVE_MAX = 3;
    localparam int STARVE_W   = $clog2(STARVE_MAX + 1);

    typedef logic [ADDR_W-1:0] rf_addr_t;
    typedef logic [DATA_W-1:0] rf_data_t;

    typedef struct packed {
        logic     valid;
        rf_addr_t addr;
        rf_data_t data;
    } wb_req_t;
endpackage

// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if: writeback requesters, reservation port and register-file write port.
interface rf_write_arbiter_if;
    import rf_pkg::*;
    logic            alu_valid;
    logic            alu_ready;
    rf_addr_t        alu_addr;
    rf_data_t        alu_data;
    logic            mem_valid;
    logic            mem_ready;
    rf_addr_t        mem_addr;
    rf_data_t        mem_data;
    logic            rsv_valid;
    rf_addr_t        rsv_addr;
    logic [NREG-1:0] busy_mask;
    logic            write_enable_ARd;
    rf_addr_t        Rd_Address;
    rf_data_t        Rd_data;
    logic            err_pc_write;

    modport master (
        output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data, rsv_valid, rsv_addr,
        input  alu_ready, mem_ready, busy_mask, write_enable_ARd, Rd_Address, Rd_data, err_pc_write
    );
    modport slave (
        input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data, rsv_valid, rsv_addr,
        output alu_ready, mem_ready, busy_mask, write_enable_ARd, Rd_Address, Rd_data, err_pc_write
    );
endinterface

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register pending bits; a new reservation beats a same-cycle completion.
module rf_scoreboard
    import rf_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            set_en,
    input  rf_addr_t        set_addr,
    input  logic            clr_en,
    input  rf_addr_t        clr_addr,
    output logic [NREG-1:0] busy_mask
);
    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] clr_vec;

    always_comb begin
        set_vec           = '0;
        clr_vec           = '0;
        set_vec[set_addr] = set_en && set_addr != rf_addr_t'(PC_IDX);
        clr_vec[clr_addr] = clr_en;
    end

    always_ff @(posedge clk) begin
        busy_mask <= !rst_n ? '0 : (busy_mask & ~clr_vec) | set_vec;
    end
endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register-file write port between ALU and load writeback,
// favouring loads but granting the ALU after STARVE_MAX consecutive losses.
module rf_write_arbiter
    import rf_pkg::*;
(
    input logic               clk,
    input logic               rst_n,
    rf_write_arbiter_if.slave bus
);
    logic [STARVE_W-1:0] starve_cnt;
    logic                alu_win;
    logic                mem_win;
    logic                pc_hit;
    wb_req_t             beat;

    always_comb begin
        alu_win = rst_n && bus.alu_valid && (!bus.mem_valid || starve_cnt == STARVE_W'(STARVE_MAX));
        mem_win = rst_n && bus.mem_valid && !alu_win;
        beat    = alu_win ? '{1'b1, bus.alu_addr, bus.alu_data} : '{mem_win, bus.mem_addr, bus.mem_data};
        pc_hit  = beat.valid && beat.addr == rf_addr_t'(PC_IDX);
    end

    assign bus.alu_ready = alu_win;
    assign bus.mem_ready = mem_win;

    // PC-targeted beats are consumed but leave the last written address/data in place
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt           <= '0;
            bus.write_enable_ARd <= 1'b0;
            bus.err_pc_write     <= 1'b0;
            bus.Rd_Address       <= '0;
            bus.Rd_data          <= '0;
        end else begin
            starve_cnt           <= (bus.alu_valid && !alu_win)
                                    ? (starve_cnt == STARVE_W'(STARVE_MAX) ? starve_cnt : starve_cnt + 1'b1)
                                    : '0;
            bus.write_enable_ARd <= beat.valid && !pc_hit;
            bus.err_pc_write     <= pc_hit;
            if (beat.valid && !pc_hit) begin
                bus.Rd_Address <= beat.addr;
                bus.Rd_data    <= beat.data;
            end
        end
    end

    rf_scoreboard u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_en    (bus.rsv_valid),
        .set_addr  (bus.rsv_addr),
        .clr_en    (beat.valid),
        .clr_addr  (beat.addr),
        .busy_mask (bus.busy_mask)
    );
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed scenarios then randomized traffic against a rule-level model.
module tb_rf_write_arbiter;
    import rf_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rf_write_arbiter_if bus();
    rf_write_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int tests = 0;
    int fails = 0;

    int          m_losses = 0;
    logic        m_we, m_err, m_ga, m_gm;
    logic [3:0]  m_addr;
    logic [31:0] m_data;
    logic [15:0] m_busy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [3:0] aa, input logic [31:0] ad,
                         input logic mv, input logic [3:0] ma, input logic [31:0] md,
                         input logic rv, input logic [3:0] ra);
        bus.alu_valid = av; bus.alu_addr = aa; bus.alu_data = ad;
        bus.mem_valid = mv; bus.mem_addr = ma; bus.mem_data = md;
        bus.rsv_valid = rv; bus.rsv_addr = ra;
    endtask

    // Called shortly after a rising edge; checks readies mid-cycle, then the registered results.
    task automatic cycle(input string tag);
        logic        ea, em, acc, av, rv, rs;
        logic [3:0]  a, ra;
        logic [31:0] d;
        #1;
        av = bus.alu_valid;
        rv = bus.rsv_valid;
        ra = bus.rsv_addr;
        rs = rst_n;
        ea = rs && av && (!bus.mem_valid || m_losses >= STARVE_MAX);
        em = rs && bus.mem_valid && !ea;
        chk({tag, ".alu_ready"}, bus.alu_ready, ea);
        chk({tag, ".mem_ready"}, bus.mem_ready, em);
        acc  = ea || em;
        a    = ea ? bus.alu_addr : bus.mem_addr;
        d    = ea ? bus.alu_data : bus.mem_data;
        m_ga = ea;
        m_gm = em;
        @(posedge clk);
        if (!rs) begin
            m_losses = 0; m_we = 0; m_err = 0; m_addr = 0; m_data = 0; m_busy = 0;
        end else begin
            m_losses = (av && !ea) ? ((m_losses + 1 > STARVE_MAX) ? STARVE_MAX : m_losses + 1) : 0;
            m_we  = acc && a != PC_IDX;
            m_err = acc && a == PC_IDX;
            if (m_we) begin
                m_addr = a;
                m_data = d;
            end
            if (acc) m_busy[a] = 1'b0;
            if (rv && ra != PC_IDX) m_busy[ra] = 1'b1;
        end
        #1;
        chk({tag, ".we"},   bus.write_enable_ARd, m_we);
        chk({tag, ".err"},  bus.err_pc_write, m_err);
        chk({tag, ".addr"}, bus.Rd_Address, m_addr);
        chk({tag, ".data"}, bus.Rd_data, m_data);
        chk({tag, ".busy"}, bus.busy_mask, m_busy);
    endtask

    logic        apend, mpend;
    logic [3:0]  raa, rma;
    logic [31:0] rad, rmd;

    initial begin
        // 1: reset held with both requesters asking
        drive(1, 3, 32'h1111, 1, 4, 32'h2222, 1, 2);
        rst_n = 0;
        cycle("t1a");
        cycle("t1b");
        chk("t1.busy0", bus.busy_mask, 16'h0);
        chk("t1.we0", bus.write_enable_ARd, 1'b0);

        // 2: single ALU beat, latency 1
        rst_n = 1;
        drive(1, 3, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
        #1 chk("t2.ready", bus.alu_ready, 1'b1);
        cycle("t2a");
        chk("t2.we", bus.write_enable_ARd, 1'b1);
        chk("t2.addr", bus.Rd_Address, 4'd3);
        chk("t2.data", bus.Rd_data, 32'hDEAD_BEEF);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cycle("t2b");
        chk("t2.we_off", bus.write_enable_ARd, 1'b0);

        // 3: contention, ALU wins every fourth cycle
        drive(1, 6, 32'hA6, 1, 5, 32'h5A, 0, 0);
        for (int i = 0; i < 8; i++) begin
            #1 chk("t3.grant", bus.alu_ready, (i % 4) == 3);
            cycle("t3");
            chk("t3.wr_addr", bus.Rd_Address, (i % 4) == 3 ? 4'd6 : 4'd5);
        end

        // 4: reservation set wins over a same-cycle completion
        drive(0, 0, 0, 0, 0, 0, 1, 7);
        cycle("t4a");
        chk("t4.set", bus.busy_mask[7], 1'b1);
        drive(0, 0, 0, 1, 7, 32'h77, 1, 7);
        cycle("t4b");
        chk("t4.keep", bus.busy_mask[7], 1'b1);
        drive(0, 0, 0, 1, 7, 32'h78, 0, 0);
        cycle("t4c");
        chk("t4.clear", bus.busy_mask[7], 1'b0);

        // 5: PC-targeted beat is dropped and flagged
        drive(0, 0, 0, 1, 15, 32'hBAD, 0, 0);
        #1 chk("t5.ready", bus.mem_ready, 1'b1);
        cycle("t5a");
        chk("t5.we", bus.write_enable_ARd, 1'b0);
        chk("t5.err", bus.err_pc_write, 1'b1);
        drive(0, 0, 0, 0, 0, 0, 1, 15);
        cycle("t5b");
        chk("t5.err_pulse", bus.err_pc_write, 1'b0);
        chk("t5.busy15", bus.busy_mask[15], 1'b0);

        // 6: reset right after an ALU beat is offered discards it
        drive(1, 9, 32'h9999, 0, 0, 0, 1, 2);
        #1 chk("t6.ready", bus.alu_ready, 1'b1);
        rst_n = 0;
        cycle("t6");
        chk("t6.we", bus.write_enable_ARd, 1'b0);
        chk("t6.addr", bus.Rd_Address, 4'd0);
        chk("t6.data", bus.Rd_data, 32'd0);
        chk("t6.busy", bus.busy_mask, 16'h0);
        rst_n = 1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cycle("t6b");

        // Randomized traffic: requesters hold their beat until accepted
        apend = 0;
        mpend = 0;
        for (int i = 0; i < 400; i++) begin
            if (!apend && $urandom_range(0, 2) != 0) begin
                apend = 1; raa = 4'($urandom_range(0, 15)); rad = $urandom;
            end
            if (!mpend && $urandom_range(0, 2) != 0) begin
                mpend = 1; rma = 4'($urandom_range(0, 15)); rmd = $urandom;
            end
            rst_n = $urandom_range(0, 59) != 0;
            drive(apend, raa, rad, mpend, rma, rmd, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)));
            cycle("rand");
            if (m_ga) apend = 0;
            if (m_gm) mpend = 0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
